board_display_reader: RTL and testbench
=======================================

Name: board_display_reader

Overview:
- Read-side companion to the game controller.
- On each refresh request it walks the 16 board cells through a read port and converts each 21-bit tile value to a log2 exponent. Each exponent is written into the tile/pixel memory of the display path.
- The 21-bit score is converted to packed BCD with a sequential double-dabble engine. Completion is signalled to the display sequencer.

Parameters:
- VAL_W, 21, width of tile values and score.
- EXP_W, 5, width of the tile exponent code.
- BCD_DIGITS, 7, number of BCD digits in score_bcd; 2^21-1 = 2097151 fits.
- NUM_CELLS, 16, board cells, row-major; index = row*4+col.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  refresh request; one-cycle pulse, honoured only when busy=0.
- score  input  VAL_W  score from the controller; sampled on the accepted start.
- cell_addr  output  4  cell index presented to the controller read port.
- cell_value  input  VAL_W  tile value at cell_addr; combinational, valid the same cycle.
- wr_en  output  1  tile-memory write strobe.
- wr_addr  output  4  tile-memory address.
- wr_data  output  EXP_W  exponent code.
- score_bcd  output  4*BCD_DIGITS  packed BCD score; most significant digit in the top nibble.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky flag: an illegal tile value was seen; cleared only by rst.

Behaviour:
- Reset values: cell_addr=0, wr_en=0, wr_addr=0, wr_data=0, score_bcd=0, busy=0, done=0, err=0, state=IDLE. All internal shift and count registers are 0.
- FSM states: IDLE -> SCAN -> BCD -> DONE -> IDLE.
- IDLE:
  - When start=1 at edge T: latch score into the bin register.
  - Clear the BCD accumulator; set cell_addr=0, busy=1; go to SCAN.
  - start=0: stay in IDLE, outputs hold.
- SCAN (cycles T+1..T+16):
  - Each cycle: wr_en=1, wr_addr=cell_addr, wr_data=code(cell_value), registered onto the next edge. Writes are therefore visible on cycles T+2..T+17, addresses 0..15 in order.
  - cell_addr increments each cycle.
  - After address 15 is read: cell_addr returns to 0, go to BCD.
  - wr_en=0 in every state other than the cycle following a SCAN read.
- Exponent code:
  - value 0 -> 0.
  - value 2^k, 1<=k<=20 -> k.
  - Any other value (1, non-powers of two) -> 5'h1F, and err is set to 1 at the same edge.
- BCD:
  - Exactly VAL_W (21) iterations.
  - Each iteration: add 3 to every BCD digit >=5, then shift {bcd,bin} left by one.
  - The iteration counter counts 0..20; on the 21st iteration go to DONE.
- DONE (one cycle):
  - score_bcd is loaded from the accumulator; done=1 for exactly this cycle; busy stays 1.
  - Next edge: busy=0, state IDLE.
  - Between refreshes score_bcd holds its last value.
- Latency: accepted start at edge T -> done high in cycle T+38.
- start while busy=1, including during DONE, is ignored; it is not queued.
- Score changes after the accepted start are ignored; the sampled value is used.
- cell_value may change between reads; each address is sampled once, in its SCAN cycle.
- rst mid-operation (any state) returns every output to its reset value at that edge. No done is produced for the aborted refresh, and score_bcd returns to 0.
- rst and start in the same cycle: rst wins, and start is dropped.

Test Plan:
- Reset: assert rst 2 cycles -> all outputs 0, busy=0. Pulse start with an all-zero board and score=0 -> 16 writes, addr 0..15, data 0. done at T+38, score_bcd=0x0000000, err=0.
- Board cells = 2^(i+1) for i=0..15, score=1234 -> wr_data = 1..16 in order, score_bcd=0x0001234, err=0.
- Cell 5=2048, cell 9=1048576, cell 3=6, all others 0, score=2097151 -> wr_data[5]=11, wr_data[9]=20, wr_data[3]=0x1F. err=1 and remains set after done; score_bcd=0x2097151.
- Back-to-back control: start pulses at T, T+10 and T+38 (the done cycle) -> exactly one refresh and one done. A start at T+39 begins a new refresh, done at T+77.
- Change score from 500 to 999 at T+5 with score=500 sampled at T -> score_bcd=0x0000500.
- Assert rst at T+20 (during BCD) -> the next cycle has busy=0, done never pulses, score_bcd=0. A new start then completes normally.

Source files
------------

// File: rtl/board_display_reader_if.sv
// Bus between the board display reader, the controller read port and the tile memory.
// The master side is the controller/display environment, and the slave side is the reader.
interface board_display_reader_if #(
  parameter int VAL_W      = 21,
  parameter int EXP_W      = 5,
  parameter int BCD_DIGITS = 7
);
  logic                    start;
  logic [VAL_W-1:0]        score;
  logic [3:0]              cell_addr;
  logic [VAL_W-1:0]        cell_value;
  logic                    wr_en;
  logic [3:0]              wr_addr;
  logic [EXP_W-1:0]        wr_data;
  logic [4*BCD_DIGITS-1:0] score_bcd;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output start, score, cell_value,
    input  cell_addr, wr_en, wr_addr, wr_data, score_bcd, busy, done, err
  );

  modport slave (
    input  start, score, cell_value,
    output cell_addr, wr_en, wr_addr, wr_data, score_bcd, busy, done, err
  );
endinterface

// File: rtl/board_display_reader.sv
// Refresh engine: scans 16 board cells into log2 tile codes for the tile memory,
// then converts the sampled score to packed BCD with a serial double-dabble.
module board_display_reader #(
  parameter int VAL_W      = 21,
  parameter int EXP_W      = 5,
  parameter int BCD_DIGITS = 7,
  parameter int NUM_CELLS  = 16
) (
  input  logic clk,
  input  logic rst,
  board_display_reader_if.slave bus
);
  localparam int BCD_W  = 4 * BCD_DIGITS;
  localparam int ITER_W = $clog2(VAL_W);

  typedef enum logic [1:0] {IDLE, SCAN, BCD, DONE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cell_addr;
  logic [VAL_W-1:0]    bin;
  logic [BCD_W-1:0]    bcd;
  logic [ITER_W-1:0]   iter;
  logic                wr_en;
  logic [3:0]          wr_addr;
  logic [EXP_W-1:0]    wr_data;
  logic [BCD_W-1:0]    score_bcd;
  logic                err;
  logic [EXP_W-1:0]    code;
  logic [BCD_W+VAL_W-1:0] shift_nxt;

  // Zero maps to 0, 2^k to k, anything else is illegal and maps to all-ones.
  function automatic logic [EXP_W-1:0] exp_code(input logic [VAL_W-1:0] v);
    logic [EXP_W-1:0] c;
    c = (v == '0) ? '0 : '1;
    for (int k = 1; k < VAL_W; k++)
      if (v == (VAL_W'(1) << k)) c = EXP_W'(k);
    return c;
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign code      = exp_code(bus.cell_value);
  assign shift_nxt = {add3(bcd), bin} << 1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = SCAN;
      end
      SCAN: if (cell_addr == 4'(NUM_CELLS - 1)) state_nxt = BCD;
      BCD:  if (iter == ITER_W'(VAL_W - 1)) state_nxt = DONE;
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_addr <= '0;
      bin       <= '0;
      bcd       <= '0;
      iter      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      score_bcd <= '0;
      err       <= 1'b0;
    end else begin
      wr_en <= (state == SCAN);
      case (state)
        IDLE: if (bus.start) begin
          bin       <= bus.score;
          bcd       <= '0;
          iter      <= '0;
          cell_addr <= '0;
        end
        SCAN: begin
          wr_addr   <= cell_addr;
          wr_data   <= code;
          cell_addr <= (cell_addr == 4'(NUM_CELLS - 1)) ? 4'd0 : cell_addr + 4'd1;
          if (code == '1) err <= 1'b1;
        end
        BCD: begin
          bcd  <= shift_nxt[BCD_W+VAL_W-1 -: BCD_W];
          bin  <= shift_nxt[VAL_W-1:0];
          iter <= iter + 1'b1;
          // The final iteration's result goes straight out so it is valid alongside done.
          if (iter == ITER_W'(VAL_W - 1)) score_bcd <= shift_nxt[BCD_W+VAL_W-1 -: BCD_W];
        end
        default: ;
      endcase
    end
  end

  assign bus.cell_addr = cell_addr;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.score_bcd = score_bcd;
  assign bus.err       = err;
endmodule

// File: tb/tb_board_display_reader.sv
// Directed and randomized refreshes checked against a decimal/log2 reference model.
module tb_board_display_reader;
  logic clk = 1'b0;
  logic rst;
  logic [20:0] board [16];
  int errors = 0;
  int checks = 0;
  logic err_model = 1'b0;

  board_display_reader_if bus ();
  board_display_reader dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.cell_value = board[bus.cell_addr];

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_code(input logic [20:0] v);
    if (v == 21'd0) return 5'd0;
    for (int k = 1; k <= 20; k++)
      if (v == (21'd1 << k)) return 5'(k);
    return 5'h1F;
  endfunction

  function automatic logic [27:0] ref_bcd(input logic [20:0] v);
    logic [27:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // One refresh started at edge T; loop index c observes cycle T+c (the interval ending at edge T+c).
  task automatic run(input logic [20:0] sc, input int ncyc, input int s2, input int s3,
                     input int chg_cyc, input logic [20:0] chg_sc, input int rst_cyc,
                     input int busy_end, input int d1, input int d2);
    logic [27:0] bcd_exp;
    logic err_exp;
    logic busy_exp;
    int wcount;
    int dq[$];
    bcd_exp = ref_bcd(sc);
    err_exp = err_model;
    wcount  = 0;
    for (int i = 0; i < 16; i++)
      if (ref_code(board[i]) == 5'h1F) err_exp = 1'b1;
    bus.score = sc;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd", 32'(bus.score_bcd), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_addr", 32'(bus.cell_addr), 32'd0);
        err_exp = 1'b0;
      end
      busy_exp = (c <= busy_end) || (d2 != 0 && c >= d2 - 37 && c <= d2);
      chk($sformatf("busy_c%0d", c), 32'(bus.busy), 32'(busy_exp));
      if (bus.wr_en) begin
        chk($sformatf("wr_addr_%0d", wcount), 32'(bus.wr_addr), 32'(wcount % 16));
        chk($sformatf("wr_data_%0d", wcount), 32'(bus.wr_data), 32'(ref_code(board[wcount % 16])));
        wcount++;
      end
      if (bus.done) begin
        dq.push_back(c);
        chk("score_bcd", 32'(bus.score_bcd), 32'(bcd_exp));
        chk("err_at_done", 32'(bus.err), 32'(err_exp));
      end
      bus.start = (c == s2) || (c == s3);
      if (c == chg_cyc) bus.score = chg_sc;
      rst = (rst_cyc != 0 && c == rst_cyc);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    rst = 1'b0;
    chk("done_count", 32'(dq.size()), 32'((d1 != 0) + (d2 != 0)));
    if (dq.size() >= 1) chk("done1_cycle", 32'(dq[0]), 32'(d1));
    if (dq.size() >= 2) chk("done2_cycle", 32'(dq[1]), 32'(d2));
    chk("write_count", 32'(wcount), 32'(16 * (1 + (d2 != 0))));
    err_model = (rst_cyc != 0) ? 1'b0 : err_exp;
    chk("err_sticky", 32'(bus.err), 32'(err_model));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.score = '0;
    for (int i = 0; i < 16; i++) board[i] = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
    chk("reset_addr", 32'(bus.cell_addr), 32'd0);
    chk("reset_bcd", 32'(bus.score_bcd), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero board, score 0.
    run(21'd0, 42, 0, 0, 0, 21'd0, 0, 38, 38, 0);

    // Ascending powers of two.
    for (int i = 0; i < 16; i++) board[i] = 21'd1 << (i + 1);
    run(21'd1234, 42, 0, 0, 0, 21'd0, 0, 38, 38, 0);

    // Mixed legal/illegal cells, maximum score.
    for (int i = 0; i < 16; i++) board[i] = '0;
    board[5] = 21'd2048;
    board[9] = 21'd1048576;
    board[3] = 21'd6;
    run(21'd2097151, 42, 0, 0, 0, 21'd0, 0, 38, 38, 0);

    // Starts during SCAN and during the done cycle are dropped.
    run(21'd4321, 45, 10, 38, 0, 21'd0, 0, 38, 38, 0);
    // A start in the first idle cycle after done begins a new refresh.
    run(21'd77, 82, 39, 0, 0, 21'd0, 0, 38, 38, 77);

    // Score changes after sampling are ignored.
    run(21'd500, 42, 0, 0, 5, 21'd999, 0, 38, 38, 0);

    // Reset during BCD aborts the refresh; a following one completes.
    for (int i = 0; i < 16; i++) board[i] = 21'd4;
    run(21'd65535, 30, 0, 0, 0, 21'd0, 20, 20, 0, 0);
    run(21'd808, 42, 0, 0, 0, 21'd0, 0, 38, 38, 0);

    // Randomized boards and scores.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 9))
          0:       board[i] = '0;
          9:       board[i] = 21'($urandom_range(1, 2097151));
          default: board[i] = 21'd1 << $urandom_range(1, 20);
        endcase
      end
      run(21'($urandom_range(0, 2097151)), 42, 0, 0, 0, 21'd0, 0, 38, 38, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
